// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit-side byte buffer that feeds a UART transmitter. User logic
// enqueues bytes into a circular FIFO at any rate. A small drain FSM hands
// them one at a time to the transmitter, paced by tx_busy. An attempted
// write into a full FIFO is flagged by a sticky overflow bit.

module uart_tx_fifo #(
  parameter int DATA_W  = 8,   // byte width, matches the UART data width
  parameter int DEPTH   = 16,  // FIFO entries, power of two, >= 2
  parameter int ADDR_W  = 4,   // log2(DEPTH)
  parameter int BUSY_TO = 32   // cycles to wait for tx_busy after a load
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_ovf,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] datain_ext,
  output logic              new_in,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // waiting for a byte and an idle transmitter
    WAIT_BUSY = 2'd1,  // load issued, waiting for tx_busy to rise
    WAIT_DONE = 2'd2   // frame in progress, waiting for tx_busy to fall
  } state_t;

  // Wide enough to hold BUSY_TO-1 for any BUSY_TO >= 1.
  localparam int              TO_W    = $clog2(BUSY_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [TO_W-1:0]   to_cnt;
  state_t            state;
  state_t            state_nxt;
  logic              wr_acc;
  logic              pop;

  // Status flags are plain decodes of the registered occupancy, so they
  // reflect the count as of the last edge and never see same-cycle traffic.
  assign full   = (count_q == CNT_MAX);
  assign empty  = (count_q == '0);
  assign count  = count_q;

  // A write into a full FIFO is refused even if a pop happens in the same
  // cycle; this keeps the full decision purely registered.
  assign wr_acc = wr_en && !full;

  // Drain FSM next-state logic; pop is the one-cycle load decision.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise any
    // path that skips an assignment would infer a latch.
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          // No response from the transmitter: treat the byte as sent.
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values of its inputs regardless of block ordering.
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake timeout counter: counts cycles spent in WAIT_BUSY only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == WAIT_BUSY && state_nxt == WAIT_BUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately left out of reset; the pointers and
    // count make stale entries unreachable, and a resettable array would
    // cost a reset net on every storage bit.
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous write and pop leave count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_acc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmitter load port: byte register plus single-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      datain_ext <= '0;
      new_in     <= 1'b0;
    end else begin
      new_in <= pop;
      if (pop) begin
        datain_ext <= mem[rd_ptr];
      end
    end
  end

  // Sticky overflow flag; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo. A behavioural transmitter model answers
// each new_in pulse with a tx_busy window, and a monitor logs every byte
// handed to the transmitter together with the cycle it appeared in.

module tb_uart_tx_fifo;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int BUSY_TO = 32;

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic              wr_en    = 1'b0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic              clr_ovf  = 1'b0;
  logic              tx_busy  = 1'b0;
  logic [DATA_W-1:0] datain_ext;
  logic              new_in;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BUSY_TO(BUSY_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .tx_busy   (tx_busy),
    .datain_ext(datain_ext),
    .new_in    (new_in),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  // Transmitter model and pulse monitor state.
  bit                model_on   = 1'b0;
  int                busy_len   = 10;
  int                busy_left  = 0;
  bit                start_d    = 1'b0;
  logic              busy_at_edge = 1'b0;
  logic              new_in_prev  = 1'b0;
  int                cyc        = 0;
  logic [DATA_W-1:0] got[$];
  int                got_cyc[$];
  int                busy_viol  = 0;
  int                b2b_viol   = 0;

  // Cycle counter and the tx_busy value the DUT sampled at each edge.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= tx_busy;
  end

  // Log pulses, flag rule violations, then advance the transmitter model:
  // tx_busy rises one cycle after a pulse and stays high busy_len cycles.
  always @(negedge clk) begin
    if (new_in) begin
      got.push_back(datain_ext);
      got_cyc.push_back(cyc);
      if (busy_at_edge) busy_viol++;
      if (new_in_prev)  b2b_viol++;
    end
    new_in_prev = new_in;
    if (model_on) begin
      if (start_d) begin
        tx_busy   = 1'b1;
        busy_left = busy_len - 1;
      end else if (busy_left > 0) begin
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
    start_d = new_in;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 2 time units past the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) tick();
  endtask

  function automatic logic [DATA_W-1:0] got_at(input int i);
    got_at = (i < got.size()) ? got[i] : 'x;
  endfunction

  function automatic int cyc_at(input int i);
    cyc_at = (i < got_cyc.size()) ? got_cyc[i] : -1000;
  endfunction

  initial begin
    // ---- Reset state ----
    #1 rst = 1'b0;
    #2;
    check("rst_count",    count,      0);
    check("rst_empty",    empty,      1);
    check("rst_full",     full,       0);
    check("rst_new_in",   new_in,     0);
    check("rst_datain",   datain_ext, 0);
    check("rst_overflow", overflow,   0);
    tick(2);
    rst = 1'b1;
    tick();

    // ---- Single byte, transmitter answers with a 10-cycle busy ----
    model_on = 1'b1;
    busy_len = 10;
    wr_en = 1'b1; wr_data = 8'h1F;
    tick();
    wr_en = 1'b0;
    check("t1_count_after_wr", count,  1);
    check("t1_empty_after_wr", empty,  0);
    check("t1_no_pulse_yet",   new_in, 0);
    tick();
    check("t1_pulse",      new_in,     1);
    check("t1_pulse_data", datain_ext, 8'h1F);
    tick();
    check("t1_pulse_width", new_in,     0);
    check("t1_data_hold",   datain_ext, 8'h1F);
    tick(20);
    check("t1_count_end", count,     0);
    check("t1_empty_end", empty,     1);
    check("t1_npulses",   got.size(), 1);
    check("t1_byte",      got_at(0), 8'h1F);

    // ---- Fill to full while the transmitter is held busy ----
    model_on = 1'b0;
    tx_busy  = 1'b1;
    got.delete();
    got_cyc.delete();
    tick();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    check("t2_count_full", count,      16);
    check("t2_full",       full,       1);
    check("t2_not_empty",  empty,      0);
    check("t2_no_pulses",  got.size(), 0);

    // ---- Overflow while full, clear, and set-over-clear priority ----
    wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("t3_ovf_set",     overflow, 1);
    check("t3_count_stays", count,    16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t3_ovf_clr", overflow, 0);
    wr_en = 1'b1; wr_data = 8'hAA; clr_ovf = 1'b1;
    tick();
    wr_en = 1'b0;
    check("t3_ovf_priority", overflow, 1);
    check("t3_count_stays2", count,    16);
    tick();
    clr_ovf = 1'b0;
    check("t3_ovf_clr2", overflow, 0);

    // ---- Release the transmitter: 16 bytes drain in order ----
    busy_left = 0;
    busy_len  = 2;
    tx_busy   = 1'b0;
    model_on  = 1'b1;
    wait_pulses(16, 400);
    check("t2_drain_npulses", got.size(), 16);
    for (int i = 0; i < 16; i++) check("t2_drain_byte", got_at(i), i + 1);
    check("t2_pulse_spacing", cyc_at(1) - cyc_at(0), 5);
    check("t2_busy_viol",     busy_viol, 0);
    check("t2_b2b_viol",      b2b_viol,  0);
    tick(10);
    check("t2_empty_end", empty, 1);
    check("t2_count_end", count, 0);

    // ---- Simultaneous write/pop at count 5, then wrap the pointers ----
    model_on = 1'b0;
    tx_busy  = 1'b1;
    got.delete();
    got_cyc.delete();
    tick();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h21 + i);
      tick();
    end
    wr_en = 1'b0;
    check("t4_count5", count,      5);
    check("t4_held",   got.size(), 0);
    wr_en = 1'b1; wr_data = 8'h26; tx_busy = 1'b0;
    tick();
    wr_en = 1'b0;
    check("t4_count_wr_pop", count,      5);
    check("t4_pulse",        new_in,     1);
    check("t4_pulse_data",   datain_ext, 8'h21);
    busy_left = 0;
    model_on  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h27 + i);
      tick();
      wr_en = 1'b0;
      tick();
    end
    wait_pulses(20, 400);
    check("t4_npulses", got.size(), 20);
    for (int i = 0; i < 20; i++) check("t4_order", got_at(i), 8'h21 + i);
    check("t4_no_ovf",    overflow,  0);
    check("t4_busy_viol", busy_viol, 0);
    check("t4_b2b_viol",  b2b_viol,  0);
    tick(10);

    // ---- Timeout: tx_busy tied low ----
    model_on = 1'b0;
    tx_busy  = 1'b0;
    got.delete();
    got_cyc.delete();
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    check("t5_pulse",      new_in,     1);
    check("t5_pulse_data", datain_ext, 8'h55);
    wait_pulses(2, 100);
    check("t5_npulses",    got.size(), 2);
    check("t5_second",     got_at(1),  8'h66);
    check("t5_timeout_gap", cyc_at(1) - cyc_at(0), BUSY_TO + 1);
    check("t5_count_end",  count, 0);
    tick(40);

    // ---- Asynchronous reset mid-drain with 7 bytes queued ----
    busy_left = 0;
    busy_len  = 10;
    model_on  = 1'b1;
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h71 + i);
      tick();
    end
    wr_en = 1'b0;
    check("t6_count7",  count,      7);
    check("t6_first",   got_at(0),  8'h71);
    check("t6_datain",  datain_ext, 8'h71);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_count",    count,      0);
    check("t6_rst_empty",    empty,      1);
    check("t6_rst_full",     full,       0);
    check("t6_rst_new_in",   new_in,     0);
    check("t6_rst_datain",   datain_ext, 0);
    check("t6_rst_overflow", overflow,   0);
    tick(2);
    rst = 1'b1;
    tick(40);
    check("t6_no_more_pulses", got.size(), 1);
    check("t6_count_end",      count,      0);
    check("t6_empty_end",      empty,      1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of `UART_top`, driving its `datain_ext`/`new_in` inputs. User logic writes bytes at any rate into a circular FIFO. A small drain FSM hands the bytes one at a time to the UART transmitter, paced by the transmitter's busy indication. Overflow is detected and held sticky, so host software never silently loses a byte.

## Interface
Parameters:
- `DATA_W`, 8: byte width; must equal the UART data width.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `BUSY_TO`, 32: cycles to wait for `tx_busy` to rise after a `new_in` pulse before giving up on that handshake.

Ports:
- `clk`  in  1: single clock; all state on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `wr_en`  in  1: write strobe from user logic.
- `wr_data`  in  DATA_W: byte to enqueue.
- `clr_ovf`  in  1: synchronous clear of `overflow`.
- `tx_busy`  in  1: high while `UART_top` is shifting a frame.
- `datain_ext`  out  DATA_W: byte presented to `UART_top`.
- `new_in`  out  1: one-cycle load strobe to `UART_top`.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `count`  out  ADDR_W+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; set when a write is attempted while full.

## Operation
- Storage is a `DEPTH` x `DATA_W` register array with `wr_ptr`/`rd_ptr` of `ADDR_W` bits, which wrap naturally modulo `DEPTH`. `count` is a separate `ADDR_W+1`-bit register.
- A write is accepted when `wr_en` is high and `full` is low: `mem[wr_ptr]` <= `wr_data`, then `wr_ptr`++.
- `full` comes from the registered `count`. A write while full is rejected even if a pop occurs in the same cycle. A rejected write sets `overflow`.
- A pop happens only in the drain FSM (below). When a write and a pop occur in the same cycle, `count` is unchanged.
- `overflow` set has priority over `clr_ovf` in the same cycle.
- Drain FSM states:
  - IDLE: if `!empty && !tx_busy`, then `datain_ext` <= `mem[rd_ptr]`, `rd_ptr`++, `count`--, `new_in` <= 1, go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: `new_in` <= 0; the timeout counter increments each cycle. If `tx_busy`, go to WAIT_DONE. Else if counter == BUSY_TO-1, go to IDLE; the byte is considered sent.
  - WAIT_DONE: when `!tx_busy`, go to IDLE.
- `datain_ext` holds its value until the next load; it is never changed while `new_in` is high.
- Reset (`rst`=0) takes effect immediately:
  - pointers, `count` and timeout counter = 0; state = IDLE;
  - `new_in` = 0, `datain_ext` = 0, `overflow` = 0, `empty` = 1, `full` = 0.
  - FIFO contents are not cleared; they are unreachable after reset.
  - Reset in mid-frame drops all queued bytes.

## Timing
- Write at edge N → `count`/`empty` update visible after edge N.
- Empty FIFO, transmitter idle: write at edge N → `new_in` high for exactly the cycle after edge N+1. Write-to-strobe latency is 2 cycles.
- `new_in` is a single-cycle pulse and is never asserted on back-to-back cycles.
- Minimum spacing between pulses is 3 cycles (IDLE → WAIT_BUSY → WAIT_DONE → IDLE) when `tx_busy` is a 1-cycle pulse.
- `tx_busy` high in IDLE blocks a load, so a frame started externally is never interrupted.
- Timeout path: a pulse with no `tx_busy` response returns to IDLE after exactly BUSY_TO cycles in WAIT_BUSY.
- `full` and `empty` are registered-count decodes, valid the cycle after the edge that changed `count`.

## Test plan
- Reset, then write 0x1F once with `tx_busy` modelled as high for 10 cycles starting 1 cycle after `new_in` → one `new_in` pulse 2 cycles after the write, `datain_ext`=0x1F; `count` returns to 0 and `empty`=1.
- Write 0x01..0x10 on consecutive cycles while `tx_busy` is held high → `full`=1 at `count`=16, no `new_in` pulse. Release `tx_busy` → 16 pulses in order 0x01..0x10, each issued only after `tx_busy` falls.
- With the FIFO full, write 0xAA → `overflow`=1 and `count` stays 16; 0xAA is never transmitted. Assert `clr_ovf` → `overflow`=0 next cycle.
- Simultaneous write and pop at `count`=5 → `count` stays 5; order is preserved across pointer wrap (write 20 bytes total through a 16-deep FIFO).
- `tx_busy` tied low, write 0x55 → `new_in` pulse, then 32 cycles in WAIT_BUSY, then return to IDLE; a following write 0x66 is issued normally.
- Assert `rst`=0 asynchronously mid-drain with 7 bytes queued → outputs reach reset values immediately (before the next edge), `count`=0, and no further `new_in` pulse after release.
